// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared definitions for the truth-table sweep stage
package sweep_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      SETTLE_WAIT = 2'd1,
      SAMPLE      = 2'd2,
      FINISH      = 2'd3
   } sweep_state_t;

   localparam int DEFAULT_N      = 4;
   localparam int NCODES         = 1 << DEFAULT_N;
   localparam int DEFAULT_SETTLE = 1;

   // Settle counter width; at least one bit so SETTLE=0 still builds.
   function automatic int settle_cnt_width(input int settle);
      return (settle < 2) ? 1 : $clog2(settle + 1);
   endfunction

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter timing the per-code hold window
module settle_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] value,
   output logic         expired
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = value;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Last wait cycle is the one where the count sits at 1.
   assign expired = (cnt_q <= W'(1));

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps all input codes and captures the truth table
module truth_table_sweeper
   import sweep_pkg::*;
#(
   parameter int N      = DEFAULT_N,
   parameter int SETTLE = DEFAULT_SETTLE
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                y_in,
   output logic [N-1:0]        a_out,
   output logic                busy,
   output logic                done,
   output logic [(1<<N)-1:0]   tt,
   output logic [N:0]          ones_count
);

   localparam int              NC       = 1 << N;
   localparam int              CW       = settle_cnt_width(SETTLE);
   localparam logic [CW-1:0]   SETTLE_V = CW'(SETTLE);
   localparam logic [N-1:0]    LAST     = '1;

   sweep_state_t    state_q, state_d;
   logic [N-1:0]    a_q, a_d;
   logic [NC-1:0]   tt_q, tt_d;
   logic [N:0]      ones_q, ones_d;
   logic            tmr_load, tmr_dec, tmr_expired;

   settle_timer #(.W(CW)) u_settle_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (tmr_load),
      .dec     (tmr_dec),
      .value   (SETTLE_V),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      tt_d     = tt_q;
      ones_d   = ones_q;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d      = '0;
               tt_d     = '0;
               ones_d   = '0;
               tmr_load = 1'b1;
               state_d  = (SETTLE == 0) ? SAMPLE : SETTLE_WAIT;
            end
         end
         SETTLE_WAIT: begin
            tmr_dec = 1'b1;
            if (tmr_expired) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            tt_d[a_q] = y_in;
            ones_d    = ones_q + {{N{1'b0}}, y_in};
            if (a_q == LAST) begin
               // Code stays at the final value; no wrap back to 0.
               state_d = FINISH;
            end else begin
               a_d      = a_q + N'(1);
               tmr_load = 1'b1;
               state_d  = (SETTLE == 0) ? SAMPLE : SETTLE_WAIT;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         tt_q    <= '0;
         ones_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         tt_q    <= tt_d;
         ones_q  <= ones_d;
      end
   end

   assign a_out      = a_q;
   assign busy       = (state_q == SETTLE_WAIT) || (state_q == SAMPLE);
   assign done       = (state_q == FINISH);
   assign tt         = tt_q;
   assign ones_count = ones_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - directed scoreboard bench for truth_table_sweeper
module tb_truth_table_sweeper;

   typedef struct {
      logic [15:0] tt;
      logic [4:0]  ones;
      int          busy_cycles;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start_i [3];
   logic        y_i     [3];
   logic [3:0]  a_o     [3];
   logic        busy_o  [3];
   logic        done_o  [3];
   logic [15:0] tt_o    [3];
   logic [4:0]  ones_o  [3];
   int          fs      [3];

   exp_t sb [$];
   int   n_vec = 0;
   int   n_err = 0;

   // Index 0: SETTLE=0, index 1: SETTLE=1 (default), index 2: SETTLE=3
   truth_table_sweeper #(.N(4), .SETTLE(0)) u_s0 (
      .clk(clk), .rst_n(rst_n), .start(start_i[0]), .y_in(y_i[0]),
      .a_out(a_o[0]), .busy(busy_o[0]), .done(done_o[0]),
      .tt(tt_o[0]), .ones_count(ones_o[0]));
   truth_table_sweeper #(.N(4), .SETTLE(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .start(start_i[1]), .y_in(y_i[1]),
      .a_out(a_o[1]), .busy(busy_o[1]), .done(done_o[1]),
      .tt(tt_o[1]), .ones_count(ones_o[1]));
   truth_table_sweeper #(.N(4), .SETTLE(3)) u_s3 (
      .clk(clk), .rst_n(rst_n), .start(start_i[2]), .y_in(y_i[2]),
      .a_out(a_o[2]), .busy(busy_o[2]), .done(done_o[2]),
      .tt(tt_o[2]), .ones_count(ones_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 0 parity, 1 const one, 2 const zero, 3 AND4
   function automatic logic fn(input int sel, input logic [3:0] a);
      case (sel)
         0: return ^a;
         1: return 1'b1;
         2: return 1'b0;
         default: return &a;
      endcase
   endfunction

   always_comb begin
      for (int k = 0; k < 3; k++) y_i[k] = fn(fs[k], a_o[k]);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [15:0] ett, input int eones, input int hold);
      exp_t e;
      e.tt          = ett;
      e.ones        = eones[4:0];
      e.busy_cycles = 16 * hold;
      sb.push_back(e);
   endtask

   // Drives start from a negedge; returns at the negedge after acceptance.
   task automatic launch(input int d, input bit keep, input logic [15:0] ett,
                         input int eones, input int hold);
      push_exp(ett, eones, hold);
      start_i[d] = 1'b1;
      @(negedge clk);
      if (!keep) start_i[d] = 1'b0;
   endtask

   // Entered in the first busy cycle; returns in the cycle after done.
   task automatic observe(input int d, input int hold, input bit poke);
      int   n;
      bit   a_bad;
      bit   poked;
      exp_t e;
      n     = 0;
      a_bad = 1'b0;
      poked = 1'b0;
      check("first_busy", 32'(busy_o[d]), 32'd1);
      check("first_code", 32'(a_o[d]), 32'd0);
      check("tt_cleared", 32'(tt_o[d]), 32'd0);
      check("ones_cleared", 32'(ones_o[d]), 32'd0);
      while (busy_o[d] === 1'b1 && n < 300) begin
         if (a_o[d] !== 4'(n / hold)) a_bad = 1'b1;
         if (done_o[d] !== 1'b0) a_bad = 1'b1;
         if (poke && !poked && a_o[d] == 4'd7) begin
            start_i[d] = 1'b1;
            poked      = 1'b1;
         end else if (poke) begin
            start_i[d] = 1'b0;
         end
         n++;
         @(negedge clk);
      end
      if (poke) start_i[d] = 1'b0;
      check("code_steps", 32'(a_bad), 32'd0);
      if (sb.size() == 0) begin
         check("sb_nonempty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check("busy_len", 32'(n), 32'(e.busy_cycles));
         check("done_pulse", 32'(done_o[d]), 32'd1);
         check("done_busy_low", 32'(busy_o[d]), 32'd0);
         check("tt", 32'(tt_o[d]), 32'(e.tt));
         check("ones_count", 32'(ones_o[d]), 32'(e.ones));
         check("final_code", 32'(a_o[d]), 32'd15);
      end
      @(negedge clk);
      check("done_one_cycle", 32'(done_o[d]), 32'd0);
   endtask

   task automatic check_zero(input int d, input string tag);
      check({tag, "_a"},    32'(a_o[d]),    32'd0);
      check({tag, "_busy"}, 32'(busy_o[d]), 32'd0);
      check({tag, "_done"}, 32'(done_o[d]), 32'd0);
      check({tag, "_tt"},   32'(tt_o[d]),   32'd0);
      check({tag, "_ones"}, 32'(ones_o[d]), 32'd0);
   endtask

   initial begin
      int n;
      exp_t dropped;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         start_i[k] = 1'b0;
         fs[k]      = 0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) check_zero(k, "reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Parity sweep with a stray start at code 7
      fs[1] = 0;
      launch(1, 1'b0, 16'h6996, 8, 2);
      observe(1, 2, 1'b1);
      check("no_queued_start", 32'(busy_o[1]), 32'd0);
      @(negedge clk);

      // All ones with start held, then all zeros back-to-back
      fs[1] = 1;
      launch(1, 1'b1, 16'hFFFF, 16, 2);
      observe(1, 2, 1'b0);
      check("idle_gap", 32'(busy_o[1]), 32'd0);
      fs[1] = 2;
      push_exp(16'h0000, 0, 2);
      @(negedge clk);
      start_i[1] = 1'b0;
      observe(1, 2, 1'b0);

      // AND4 at SETTLE=0 and SETTLE=3
      fs[0] = 3;
      launch(0, 1'b0, 16'h8000, 1, 1);
      observe(0, 1, 1'b0);
      fs[2] = 3;
      launch(2, 1'b0, 16'h8000, 1, 4);
      observe(2, 4, 1'b0);

      // Asynchronous reset while code 5 is driven
      fs[1] = 0;
      launch(1, 1'b0, 16'h6996, 8, 2);
      n = 0;
      while (a_o[1] !== 4'd5 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("reached_code5", 32'(a_o[1]), 32'd5);
      dropped = sb.pop_front();
      #2 rst_n = 1'b0;
      #1 check_zero(1, "async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      launch(1, 1'b0, 16'h6996, 8, 2);
      observe(1, 2, 1'b0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
